// File: rtl/slon5_pkg.sv
// Shared types, glyph constants and sizing helpers for the display scan controller.
package slon5_pkg;

  localparam int DIGITS_DEF = 4;

  typedef logic [7:0]            Dout_t;
  typedef logic [DIGITS_DEF-1:0] Dnum_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Segment bits a..g in positions 0..6, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Timer width able to count 0..max(a,b)-1, never narrower than one bit.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Write port of the scan controller: valid/ready handshake carrying one full display value.
interface disp_scan_ctrl_if #(
  parameter int DIGITS = slon5_pkg::DIGITS_DEF
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_dp;

  modport master (output wr_valid, output wr_data, output wr_dp, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  wr_dp, output wr_ready);
endinterface

// File: rtl/hex2seg_m.sv
// Combinational hex nibble to seven-segment glyph, with the decimal point on bit 7.
module hex2seg_m
  import slon5_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output Dout_t      seg
);

  always_comb begin
    seg = '0;
    case (nibble)
      4'h0: seg[6:0] = SEG_0;
      4'h1: seg[6:0] = SEG_1;
      4'h2: seg[6:0] = SEG_2;
      4'h3: seg[6:0] = SEG_3;
      4'h4: seg[6:0] = SEG_4;
      4'h5: seg[6:0] = SEG_5;
      4'h6: seg[6:0] = SEG_6;
      4'h7: seg[6:0] = SEG_7;
      4'h8: seg[6:0] = SEG_8;
      4'h9: seg[6:0] = SEG_9;
      4'hA: seg[6:0] = SEG_A;
      4'hB: seg[6:0] = SEG_B;
      4'hC: seg[6:0] = SEG_C;
      4'hD: seg[6:0] = SEG_D;
      4'hE: seg[6:0] = SEG_E;
      4'hF: seg[6:0] = SEG_F;
      default: seg[6:0] = SEG_0;
    endcase
    seg[7] = dp;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scan controller: dwell/blank per digit, with new
// display values committed only at frame boundaries so no digit mixes values.
module disp_scan_ctrl
  import slon5_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  disp_scan_ctrl_if.slave   wr,
  output Dout_t             dout,
  output logic [DIGITS-1:0] dnum,
  output logic              frame_sync
);

  localparam int TW = tmr_width(DWELL, BLANK);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_DWELL = 2'(ST_DWELL);
  localparam logic [1:0] S_BLANK = 2'(ST_BLANK);

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_full_q, pend_full_d;
  logic                rdy_q;
  Dout_t               dout_q, dout_d;
  logic [DIGITS-1:0]   dnum_q, dnum_d;
  logic                fs_q, fs_d;

  logic                wrap;
  logic                xfer;
  logic                accept;
  logic                wr_ready_int;
  Dout_t               seg_sel;
  logic [DIGITS-1:0]   sel_onehot;
  Dout_t               glyph [DIGITS];

  // rdy_q keeps wr_ready low while in reset and for the cycle of release.
  assign wr_ready_int = rdy_q & ~pend_full_q;
  assign wr.wr_ready  = wr_ready_int;
  assign accept       = wr.wr_valid & wr_ready_int;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    wrap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_DWELL;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      S_DWELL: begin
        if (!en) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmr_d   = '0;
        end else if (tmr_q == DWELL_LAST) begin
          state_d = S_BLANK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_BLANK: begin
        if (!en) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmr_d   = '0;
        end else if (tmr_q == BLANK_LAST) begin
          state_d = S_DWELL;
          tmr_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        tmr_d   = '0;
      end
    endcase
    fs_d = wrap;
  end

  // Pending data only reaches the display between frames, never mid-frame.
  assign xfer = pend_full_q & (wrap | (state_q == S_IDLE));

  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (xfer) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_data_d = wr.wr_data;
      pend_dp_d   = wr.wr_dp;
      pend_full_d = 1'b1;
    end
  end

  // Digit 0 shows the leftmost nibble of the written value, so a value reads
  // across the display in the same order as its hex literal.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
    hex2seg_m u_hex2seg (
      .nibble (act_data_q[4*(DIGITS-1-gi) +: 4]),
      .dp     (act_dp_q[gi]),
      .seg    (glyph[gi])
    );
  end

  always_comb begin
    seg_sel    = '0;
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        seg_sel       = glyph[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Gating with en blanks the pins in the same cycle the FSM heads to IDLE.
  always_comb begin
    dout_d = '0;
    dnum_d = '0;
    if ((state_q == S_DWELL) && en) begin
      dout_d = seg_sel;
      dnum_d = sel_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      rdy_q       <= 1'b0;
      dout_q      <= '0;
      dnum_q      <= '0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      rdy_q       <= 1'b1;
      dout_q      <= dout_d;
      dnum_q      <= dnum_d;
      fs_q        <= fs_d;
    end
  end

  assign dout       = dout_q;
  assign dnum       = dnum_q;
  assign frame_sync = fs_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIGITS=4, DWELL=4, BLANK=2 (24-cycle frame).
module tb_disp_scan_ctrl;
  import slon5_pkg::*;

  localparam int NDIG   = 4;
  localparam int NDWELL = 4;
  localparam int NBLANK = 2;
  localparam int SLOT   = NDWELL + NBLANK;
  localparam int FRAME  = NDIG * SLOT;

  logic       clk;
  logic       rst_n;
  logic       en;
  Dout_t      dout;
  logic [3:0] dnum;
  logic       frame_sync;

  int n_tests = 0;
  int n_fail  = 0;

  disp_scan_ctrl_if #(.DIGITS(NDIG)) wr_if ();

  disp_scan_ctrl #(.DIGITS(NDIG), .DWELL(NDWELL), .BLANK(NBLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr         (wr_if),
    .dout       (dout),
    .dnum       (dnum),
    .frame_sync (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wv;
    logic [15:0] wd;
    logic [3:0]  wdp;
    Dout_t       x_dout;
    logic [3:0]  x_dnum;
    logic        x_fs;
    logic        x_rdy;
    int          n;
  } vec_t;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // n counts clock edges since the enabling edge; n=1 is the first lit cycle.
  function automatic logic [3:0] x_dnum(input int n);
    int p;
    if (n < 1) return 4'b0000;
    p = (n - 1) % FRAME;
    if ((p % SLOT) < NDWELL) return 4'(1 << (p / SLOT));
    return 4'b0000;
  endfunction

  function automatic Dout_t x_dout(input int n, input logic [15:0] v, input logic [3:0] dp);
    int d;
    logic [15:0] vv;
    logic [3:0] nib;
    if (x_dnum(n) == 4'b0000) return 8'h00;
    d   = ((n - 1) % FRAME) / SLOT;
    vv  = v;
    nib = vv[4*(NDIG-1-d) +: 4];
    return {dp[d], glyph(nib)};
  endfunction

  function automatic logic x_fs(input int n);
    return (n > 0) && ((n % FRAME) == 0);
  endfunction

  function automatic logic [15:0] bp_data(input int n);
    return 16'(n * 32'h1357);
  endfunction

  function automatic vec_t mk(input logic e, input logic wv, input logic [15:0] wd,
                              input logic [3:0] wdp, input Dout_t xd, input logic [3:0] xn,
                              input logic xf, input logic xr, input int n);
    vec_t r;
    r.en = e; r.wv = wv; r.wd = wd; r.wdp = wdp;
    r.x_dout = xd; r.x_dnum = xn; r.x_fs = xf; r.x_rdy = xr; r.n = n;
    return r;
  endfunction

  task automatic drive(input logic e, input logic wv, input logic [15:0] wd, input logic [3:0] wdp);
    en             = e;
    wr_if.wr_valid = wv;
    wr_if.wr_data  = wd;
    wr_if.wr_dp    = wdp;
  endtask

  task automatic compare(input string name, input int n, input Dout_t xd, input logic [3:0] xn,
                         input logic xf, input logic xr);
    n_tests++;
    if (dout !== xd || dnum !== xn || frame_sync !== xf || wr_if.wr_ready !== xr) begin
      n_fail++;
      $display("[TB] FAIL %s n=%0d: got dout=%02h dnum=%b fs=%b rdy=%b, want dout=%02h dnum=%b fs=%b rdy=%b",
               name, n, dout, dnum, frame_sync, wr_if.wr_ready, xd, xn, xf, xr);
    end else begin
      $display("[TB] ok   %s n=%0d dout=%02h dnum=%b fs=%b rdy=%b",
               name, n, dout, dnum, frame_sync, wr_if.wr_ready);
    end
  endtask

  task automatic tick_check(input string name, input int n, input Dout_t xd, input logic [3:0] xn,
                            input logic xf, input logic xr);
    @(posedge clk);
    #1;
    compare(name, n, xd, xn, xf, xr);
  endtask

  task automatic scan(input string name, input int n, input logic [15:0] v, input logic [3:0] dp,
                      input logic xr);
    tick_check(name, n, x_dout(n, v, dp), x_dnum(n), x_fs(n), xr);
  endtask

  initial begin
    vec_t        vecs[$];
    logic        wv;
    logic [15:0] wd;
    logic [15:0] shown;
    logic        xr;
    string       ph;
    logic [15:0] sweep_val [4];
    logic [3:0]  sweep_dp  [4];

    // Write 0x1234 while idle, then scan two frames, update mid-frame at n=58,
    // then hold wr_valid with changing data from n=97 on.
    vecs.push_back(mk(1'b0, 1'b1, 16'h1234, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, -1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1, -1));
    for (int n = 0; n <= 168; n++) begin
      wv = (n == 58) || (n >= 97);
      wd = (n == 58) ? 16'hABCD : bp_data(n);
      if (n <= 72)       shown = 16'h1234;
      else if (n <= 120) shown = 16'hABCD;
      else if (n <= 144) shown = bp_data(97);
      else               shown = bp_data(121);
      if (n < 58)        xr = 1'b1;
      else if (n <= 71)  xr = 1'b0;
      else if (n <= 96)  xr = 1'b1;
      else               xr = ((n % FRAME) == 0);
      vecs.push_back(mk(1'b1, wv, wd, 4'h0, x_dout(n, shown, 4'h0), x_dnum(n), x_fs(n), xr, n));
    end

    sweep_val[0] = 16'h0123; sweep_dp[0] = 4'b1001;
    sweep_val[1] = 16'h4567; sweep_dp[1] = 4'b0110;
    sweep_val[2] = 16'h89AB; sweep_dp[2] = 4'b1010;
    sweep_val[3] = 16'hCDEF; sweep_dp[3] = 4'b0101;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 4'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      compare("reset_hold", -1, 8'h00, 4'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick_check("reset_release", -1, 8'h00, 4'h0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      if (vecs[i].n < 0)        ph = "wr_setup";
      else if (vecs[i].n <= 48) ph = "basic_scan";
      else if (vecs[i].n <= 96) ph = "frame_update";
      else                      ph = "backpressure";
      drive(vecs[i].en, vecs[i].wv, vecs[i].wd, vecs[i].wdp);
      tick_check(ph, vecs[i].n, vecs[i].x_dout, vecs[i].x_dnum, vecs[i].x_fs, vecs[i].x_rdy);
    end

    // en dropped while digit 2 is lit; the pending write must show after restart.
    for (int n = 169; n <= 182; n++) begin
      if (n == 170) drive(1'b1, 1'b1, 16'h5A0F, 4'b0100);
      else          drive(1'b1, 1'b0, 16'h0000, 4'h0);
      scan("en_drop_pre", n, bp_data(145), 4'h0, (n == 169));
    end
    drive(1'b0, 1'b0, 16'h0000, 4'h0);
    tick_check("en_drop_blank", 183, 8'h00, 4'h0, 1'b0, 1'b0);
    tick_check("en_drop_xfer", 184, 8'h00, 4'h0, 1'b0, 1'b1);
    tick_check("en_drop_idle", 185, 8'h00, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 4'h0);
    for (int n = 0; n <= FRAME; n++) scan("en_restart", n, 16'h5A0F, 4'b0100, 1'b1);

    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, sweep_val[k], sweep_dp[k]);
      tick_check("sweep_load", k, 8'h00, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 16'h0000, 4'h0);
      tick_check("sweep_xfer", k, 8'h00, 4'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'h0000, 4'h0);
      for (int n = 0; n <= FRAME; n++) scan("glyph_sweep", n, sweep_val[k], sweep_dp[k], 1'b1);
    end

    // Reset pulse in the first BLANK cycle while digit 0 is still on the pins.
    drive(1'b0, 1'b0, 16'h0000, 4'h0);
    tick_check("pre_rst_idle", -1, 8'h00, 4'h0, 1'b0, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      if (n == 2) drive(1'b1, 1'b1, 16'h7777, 4'hF);
      else        drive(1'b1, 1'b0, 16'h0000, 4'h0);
      scan("pre_rst", n, 16'hCDEF, 4'b0101, (n < 2));
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 4'h0);
    #1;
    compare("async_rst", -1, 8'h00, 4'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick_check("post_rst_ready", -1, 8'h00, 4'h0, 1'b0, 1'b1);
    repeat (2) tick_check("post_rst_blank", -1, 8'h00, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 4'h0);
    for (int n = 0; n <= 6; n++) scan("post_rst_scan", n, 16'h0000, 4'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
